// File: rtl/mchan_pkg.sv
// Shared mchan types: the per-tag transfer descriptor and the default sizing of the tag buffer.
package mchan_pkg;

   localparam int DESC_OPC_W     = 12;
   localparam int DESC_LEN_W     = 15;
   localparam int DESC_EXT_ADD_W = 3;
   localparam int DESC_TCDM_W    = 12;
   localparam int DESC_SID_W     = 2;
   localparam int DESC_TID_W     = 4;

   localparam int OPC_BUF_WIDTH = DESC_OPC_W + DESC_LEN_W + DESC_EXT_ADD_W + DESC_TCDM_W + DESC_SID_W;
   localparam int OPC_BUF_DEPTH = 2 ** DESC_TID_W;

   typedef struct packed {
      logic [DESC_OPC_W-1:0]     opc;
      logic [DESC_LEN_W-1:0]     len;
      logic [DESC_EXT_ADD_W-1:0] ext_add;
      logic [DESC_TCDM_W-1:0]    tcdm_add;
      logic [DESC_SID_W-1:0]     sid;
   } mchan_desc_t;

endpackage

// File: rtl/tid_prio_enc.sv
// Lowest-index free-tag finder: returns the first entry whose valid bit is clear (0 when none is free).
module tid_prio_enc #(
   parameter int TID_WIDTH = 4
) (
   input  logic [(2**TID_WIDTH)-1:0] i_valid,
   output logic [TID_WIDTH-1:0]      o_tid
);

   localparam int DEPTH = 2 ** TID_WIDTH;

   // Scanning downwards lets the lowest free index win the last assignment.
   always_comb begin
      o_tid = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!i_valid[i]) begin
            o_tid = TID_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/ext_tid_tracker.sv
// External transaction tag tracker: hands out free tags, stores each tag's descriptor and
// returns it, zero latency, when the response for that tag arrives.
module ext_tid_tracker
   import mchan_pkg::*;
#(
   parameter int EXT_TID_WIDTH   = 4,
   parameter int TCDM_OPC_WIDTH  = 12,
   parameter int TCDM_ADD_WIDTH  = 12,
   parameter int MCHAN_LEN_WIDTH = 15,
   parameter int TRANS_SID_WIDTH = 2,
   parameter int SWAP_OPC        = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       alloc_req_i,
   input  logic [TCDM_OPC_WIDTH-1:0]  opc_i,
   input  logic [MCHAN_LEN_WIDTH-1:0] len_i,
   input  logic [TCDM_ADD_WIDTH-1:0]  r_add_i,
   input  logic [2:0]                 add_i,
   input  logic [TRANS_SID_WIDTH-1:0] sid_i,
   output logic                       alloc_gnt_o,
   output logic [EXT_TID_WIDTH-1:0]   alloc_tid_o,
   input  logic                       rsp_valid_i,
   input  logic                       rsp_last_i,
   input  logic [EXT_TID_WIDTH-1:0]   rsp_tid_i,
   output logic [TCDM_OPC_WIDTH-1:0]  tcdm_opc_o,
   output logic [MCHAN_LEN_WIDTH-1:0] tcdm_len_o,
   output logic [TCDM_ADD_WIDTH-1:0]  tcdm_add_o,
   output logic [TRANS_SID_WIDTH-1:0] tcdm_sid_o,
   output logic [2:0]                 trans_rx_ext_add_o,
   output logic [2:0]                 trans_rx_tcdm_add_o,
   output logic                       rsp_err_o,
   input  logic                       flush_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [EXT_TID_WIDTH:0]     outstanding_o
);

   localparam int DEPTH = 2 ** EXT_TID_WIDTH;
   localparam logic [EXT_TID_WIDTH:0] FULL_CNT = (EXT_TID_WIDTH + 1)'(DEPTH);
   localparam logic [TCDM_OPC_WIDTH-1:0] SWAP_MASK = (SWAP_OPC != 0) ? TCDM_OPC_WIDTH'(1) : '0;

   logic [DEPTH-1:0]         r_valid;
   mchan_desc_t              r_buf [DEPTH];
   logic [EXT_TID_WIDTH:0]   r_outstanding;

   logic [EXT_TID_WIDTH-1:0] w_free_tid;
   logic                     w_grant;
   logic                     w_retire;
   logic                     w_tid_live;
   mchan_desc_t              w_new;
   mchan_desc_t              w_rd;

   tid_prio_enc #(
      .TID_WIDTH (EXT_TID_WIDTH)
   ) u_prio_enc (
      .i_valid (r_valid),
      .o_tid   (w_free_tid)
   );

   assign full_o        = (r_outstanding == FULL_CNT);
   assign empty_o       = (r_outstanding == '0);
   assign outstanding_o = r_outstanding;
   assign alloc_tid_o   = w_free_tid;
   assign alloc_gnt_o   = alloc_req_i & ~full_o & ~flush_i;

   assign w_tid_live = r_valid[rsp_tid_i];
   assign rsp_err_o  = rsp_valid_i & ~w_tid_live;
   assign w_grant    = alloc_gnt_o;
   assign w_retire   = rsp_valid_i & rsp_last_i & w_tid_live & ~flush_i;

   always_comb begin
      w_new          = '0;
      w_new.opc      = DESC_OPC_W'(opc_i);
      w_new.len      = DESC_LEN_W'(len_i);
      w_new.ext_add  = DESC_EXT_ADD_W'(add_i);
      w_new.tcdm_add = DESC_TCDM_W'(r_add_i);
      w_new.sid      = DESC_SID_W'(sid_i);
   end

   assign w_rd                = r_buf[rsp_tid_i];
   assign tcdm_opc_o          = TCDM_OPC_WIDTH'(w_rd.opc) ^ SWAP_MASK;
   assign tcdm_len_o          = MCHAN_LEN_WIDTH'(w_rd.len);
   assign tcdm_add_o          = TCDM_ADD_WIDTH'(w_rd.tcdm_add);
   assign tcdm_sid_o          = TRANS_SID_WIDTH'(w_rd.sid);
   assign trans_rx_ext_add_o  = 3'(w_rd.ext_add);
   assign trans_rx_tcdm_add_o = tcdm_add_o[2:0];

   // Grant and retire never target the same entry: grant picks a free slot, retire a live one.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid       <= '0;
         r_outstanding <= '0;
      end else if (flush_i) begin
         r_valid       <= '0;
         r_outstanding <= '0;
      end else begin
         if (w_grant) begin
            r_valid[w_free_tid] <= 1'b1;
         end
         if (w_retire) begin
            r_valid[rsp_tid_i] <= 1'b0;
         end
         case ({w_grant, w_retire})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // Payload survives a flush; only reset wipes it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_buf[i] <= '0;
         end
      end else if (w_grant) begin
         r_buf[w_free_tid] <= w_new;
      end
   end

endmodule

// File: tb/tb_ext_tid_tracker.sv
// Randomized self-checking bench for ext_tid_tracker against a tag-table reference model.
module tb_ext_tid_tracker;

   localparam int TW    = 4;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rstN;
   logic        allocReq;
   logic [11:0] opc;
   logic [14:0] len;
   logic [11:0] rAdd;
   logic [2:0]  add;
   logic [1:0]  sid;
   logic        rspValid;
   logic        rspLast;
   logic [3:0]  rspTid;
   logic        flush;

   logic        gnt, rspErr, full, empty;
   logic [3:0]  tid;
   logic [11:0] tcdmOpc, tcdmAdd;
   logic [14:0] tcdmLen;
   logic [1:0]  tcdmSid;
   logic [2:0]  extAdd, tcdmAdd3;
   logic [4:0]  outstanding;

   logic        gnt0, rspErr0, full0, empty0;
   logic [3:0]  tid0;
   logic [11:0] tcdmOpc0, tcdmAdd0;
   logic [14:0] tcdmLen0;
   logic [1:0]  tcdmSid0;
   logic [2:0]  extAdd0, tcdmAddLow0;
   logic [4:0]  outstanding0;

   int checks = 0;
   int errors = 0;

   bit          mLive [DEPTH];
   logic [11:0] mOpc  [DEPTH];
   logic [14:0] mLen  [DEPTH];
   logic [11:0] mRAdd [DEPTH];
   logic [2:0]  mAdd  [DEPTH];
   logic [1:0]  mSid  [DEPTH];

   always #5 clk = ~clk;

   ext_tid_tracker #(.SWAP_OPC(1)) dut (
      .clk_i(clk), .rst_ni(rstN), .alloc_req_i(allocReq), .opc_i(opc), .len_i(len),
      .r_add_i(rAdd), .add_i(add), .sid_i(sid), .alloc_gnt_o(gnt), .alloc_tid_o(tid),
      .rsp_valid_i(rspValid), .rsp_last_i(rspLast), .rsp_tid_i(rspTid),
      .tcdm_opc_o(tcdmOpc), .tcdm_len_o(tcdmLen), .tcdm_add_o(tcdmAdd), .tcdm_sid_o(tcdmSid),
      .trans_rx_ext_add_o(extAdd), .trans_rx_tcdm_add_o(tcdmAdd3), .rsp_err_o(rspErr),
      .flush_i(flush), .full_o(full), .empty_o(empty), .outstanding_o(outstanding)
   );

   ext_tid_tracker #(.SWAP_OPC(0)) dutNoSwap (
      .clk_i(clk), .rst_ni(rstN), .alloc_req_i(allocReq), .opc_i(opc), .len_i(len),
      .r_add_i(rAdd), .add_i(add), .sid_i(sid), .alloc_gnt_o(gnt0), .alloc_tid_o(tid0),
      .rsp_valid_i(rspValid), .rsp_last_i(rspLast), .rsp_tid_i(rspTid),
      .tcdm_opc_o(tcdmOpc0), .tcdm_len_o(tcdmLen0), .tcdm_add_o(tcdmAdd0), .tcdm_sid_o(tcdmSid0),
      .trans_rx_ext_add_o(extAdd0), .trans_rx_tcdm_add_o(tcdmAddLow0), .rsp_err_o(rspErr0),
      .flush_i(flush), .full_o(full0), .empty_o(empty0), .outstanding_o(outstanding0)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int mCount();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += mLive[i] ? 1 : 0;
      return n;
   endfunction

   function automatic int mFree();
      for (int i = 0; i < DEPTH; i++) if (!mLive[i]) return i;
      return -1;
   endfunction

   function automatic void mClear();
      for (int i = 0; i < DEPTH; i++) begin
         mLive[i] = 1'b0; mOpc[i] = '0; mLen[i] = '0; mRAdd[i] = '0; mAdd[i] = '0; mSid[i] = '0;
      end
   endfunction

   task automatic applyStimulus(input logic req, input logic [11:0] o, input logic [14:0] l,
                                input logic [11:0] ra, input logic [2:0] a, input logic [1:0] s,
                                input logic rv, input logic rl, input logic [3:0] rt, input logic fl);
      allocReq = req; opc = o; len = l; rAdd = ra; add = a; sid = s;
      rspValid = rv; rspLast = rl; rspTid = rt; flush = fl;
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic checkAll();
      int cnt = mCount();
      int fr = mFree();
      bit expFull = (cnt == DEPTH);
      bit expGnt = allocReq && !expFull && !flush;
      int t = rspTid;
      logic [11:0] ra = mRAdd[t];
      checkOutput("alloc_gnt", gnt, expGnt);
      checkOutput("alloc_gnt_noswap", gnt0, expGnt);
      if (!expFull) checkOutput("alloc_tid", tid, fr);
      checkOutput("full", full, expFull);
      checkOutput("empty", empty, cnt == 0);
      checkOutput("outstanding", outstanding, cnt);
      checkOutput("rsp_err", rspErr, rspValid && !mLive[t]);
      checkOutput("tcdm_opc", tcdmOpc, mOpc[t] ^ 12'h001);
      checkOutput("tcdm_opc_noswap", tcdmOpc0, mOpc[t]);
      checkOutput("tcdm_len", tcdmLen, mLen[t]);
      checkOutput("tcdm_add", tcdmAdd, ra);
      checkOutput("tcdm_sid", tcdmSid, mSid[t]);
      checkOutput("ext_add", extAdd, mAdd[t]);
      checkOutput("tcdm_add_low", tcdmAdd3, ra[2:0]);
   endtask

   // Checks the current cycle, then advances the model across the clock edge.
   task automatic stepCycle();
      bit doGrant, doRetire;
      int fr, t;
      #1;
      checkAll();
      fr = mFree();
      t = rspTid;
      doGrant = allocReq && (fr >= 0) && !flush;
      doRetire = rspValid && rspLast && mLive[t];
      @(posedge clk);
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) mLive[i] = 1'b0;
      end else begin
         if (doGrant) begin
            mLive[fr] = 1'b1; mOpc[fr] = opc; mLen[fr] = len; mRAdd[fr] = rAdd; mAdd[fr] = add; mSid[fr] = sid;
         end
         if (doRetire) mLive[t] = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic allocRandom();
      applyStimulus(1'b1, 12'($urandom), 15'($urandom), 12'($urandom), 3'($urandom), 2'($urandom),
                    1'b0, 1'b0, 4'($urandom), 1'b0);
      stepCycle();
   endtask

   task automatic doReset();
      rstN = 1'b0;
      #1;
      mClear();
      checkAll();
      checkOutput("reset_rsp_err", rspErr, 1'b0);
      checkOutput("reset_alloc_tid", tid, 4'd0);
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
   endtask

   initial begin
      applyIdle();
      rstN = 1'b1;
      mClear();
      #1;
      doReset();

      // Sixteen back-to-back allocations fill the buffer in tag order.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 12'(i), 15'(i * 3), 12'(i * 7), 3'(i), 2'(i), 1'b0, 1'b0, '0, 1'b0);
         #1;
         checkOutput("fill_tid", tid, i);
         stepCycle();
      end
      applyStimulus(1'b1, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      #1;
      checkOutput("full_after_16", full, 1'b1);
      checkOutput("gnt_17th", gnt, 1'b0);
      stepCycle();

      // Retiring tag 5 on a full buffer: no grant that cycle, tag 5 reused the next.
      applyStimulus(1'b1, 12'h0AA, 15'h123, 12'h456, 3'd6, 2'd1, 1'b1, 1'b1, 4'd5, 1'b0);
      #1;
      checkOutput("retire_full_gnt", gnt, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 12'h0AB, 15'h124, 12'h457, 3'd7, 2'd2, 1'b0, 1'b0, 4'd5, 1'b0);
      #1;
      checkOutput("reuse_tid5", tid, 4'd5);
      checkOutput("reuse_gnt", gnt, 1'b1);
      stepCycle();
      applyIdle();
      #1;
      checkOutput("outstanding_16", outstanding, 5'd16);
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
      stepCycle();

      // Tag 3 carries opc 0x001 so the swap and no-swap readouts differ.
      for (int i = 0; i < 3; i++) allocRandom();
      applyStimulus(1'b1, 12'h001, 15'h040, 12'h0F5, 3'd2, 2'd3, 1'b0, 1'b0, '0, 1'b0);
      stepCycle();
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b0, 4'd3, 1'b0);
      #1;
      checkOutput("opc_swapped", tcdmOpc, 12'h000);
      checkOutput("opc_unswapped", tcdmOpc0, 12'h001);
      checkOutput("len_tag3", tcdmLen, 15'h040);
      stepCycle();

      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b1, 4'd7, 1'b0);
      #1;
      checkOutput("err_tag7", rspErr, 1'b1);
      stepCycle();
      applyIdle();
      #1;
      checkOutput("outstanding_after_err", outstanding, 5'd4);

      // Flush with a concurrent request: no grant, then an empty buffer.
      applyStimulus(1'b1, 12'h3C3, '0, '0, '0, '0, 1'b1, 1'b1, 4'd1, 1'b1);
      #1;
      checkOutput("flush_gnt", gnt, 1'b0);
      stepCycle();
      applyIdle();
      #1;
      checkOutput("flush_outstanding", outstanding, 5'd0);
      checkOutput("flush_empty", empty, 1'b1);
      checkOutput("flush_next_tid", tid, 4'd0);

      for (int c = 0; c < 800; c++) begin
         int cnt = mCount();
         int k = $urandom_range(DEPTH - 1);
         logic [3:0] rt = 4'(k);
         if (cnt > 0 && $urandom_range(3) != 0) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (mLive[(k + j) % DEPTH]) begin
                  rt = 4'((k + j) % DEPTH);
                  break;
               end
            end
         end
         applyStimulus($urandom_range(9) < 6, 12'($urandom), 15'($urandom), 12'($urandom),
                       3'($urandom), 2'($urandom), $urandom_range(1) == 1, $urandom_range(1) == 1,
                       rt, $urandom_range(39) == 0);
         stepCycle();
      end

      // Asynchronous reset with ten tags live.
      applyIdle();
      stepCycle();
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
      stepCycle();
      for (int i = 0; i < 10; i++) allocRandom();
      applyIdle();
      #1;
      checkOutput("live_before_reset", outstanding, 5'd10);
      #1;
      doReset();
      checkOutput("post_reset_empty", empty, 1'b1);
      applyStimulus(1'b1, 12'h777, 15'h1, 12'h2, 3'd3, 2'd0, 1'b0, 1'b0, '0, 1'b0);
      #1;
      checkOutput("post_reset_tid", tid, 4'd0);
      checkOutput("post_reset_gnt", gnt, 1'b1);
      stepCycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ext_tid_tracker.md
EXT_TID_TRACKER -- requirements
Module: ext_tid_tracker

Interface
REQ-001 SHALL have parameter EXT_TID_WIDTH, default 4: tag width; buffer depth is 2**EXT_TID_WIDTH entries.
REQ-002 SHALL have parameter TCDM_OPC_WIDTH, default 12: opcode width.
REQ-003 SHALL have parameter TCDM_ADD_WIDTH, default 12: TCDM address width.
REQ-004 SHALL have parameter MCHAN_LEN_WIDTH, default 15: transfer length width.
REQ-005 SHALL have parameter TRANS_SID_WIDTH, default 2: stream-id width.
REQ-006 SHALL have parameter SWAP_OPC, default 1: 1 inverts opcode bit 0 on readout; 0 returns the opcode unchanged.
REQ-007 SHALL have port clk_i  in  1  the single clock; all state on its rising edge.
REQ-008 SHALL have port rst_ni  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port alloc_req_i  in  1  request for a new tag.
REQ-010 SHALL have ports opc_i, len_i, r_add_i, add_i(3), sid_i  in  parameter widths  descriptor to store on allocation.
REQ-011 SHALL have port alloc_gnt_o  out  1  allocation accepted this cycle.
REQ-012 SHALL have port alloc_tid_o  out  EXT_TID_WIDTH  granted tag.
REQ-013 SHALL have ports rsp_valid_i, rsp_last_i  in  1 each  response beat and last beat.
REQ-014 SHALL have port rsp_tid_i  in  EXT_TID_WIDTH  response tag.
REQ-015 SHALL have ports tcdm_opc_o, tcdm_len_o, tcdm_add_o, tcdm_sid_o, trans_rx_ext_add_o(3), trans_rx_tcdm_add_o(3)  out  descriptor of rsp_tid_i.
REQ-016 SHALL have port rsp_err_o  out  1  response to an unallocated tag.
REQ-017 SHALL have port flush_i  in  1  synchronous clear of all tags.
REQ-018 SHALL have ports full_o, empty_o  out  1 each, and outstanding_o  out  EXT_TID_WIDTH+1  live-tag count.

Function
REQ-019 SHALL keep one valid bit per entry; alloc_tid_o SHALL be the lowest-index entry whose valid bit is clear.
REQ-020 alloc_gnt_o SHALL equal alloc_req_i AND NOT full_o AND NOT flush_i, combinationally.
REQ-021 On grant, the entry SHALL store {opc_i, len_i, add_i, r_add_i, sid_i} and set its valid bit at the next edge.
REQ-022 Readout SHALL be combinational from entry rsp_tid_i, zero latency.
REQ-023 trans_rx_tcdm_add_o SHALL equal tcdm_add_o[2:0].
REQ-024 rsp_err_o SHALL equal rsp_valid_i AND NOT valid[rsp_tid_i].
REQ-025 rsp_valid_i AND rsp_last_i on a valid tag SHALL clear that valid bit at the next edge; non-last beats SHALL leave state unchanged.
REQ-026 Errored responses SHALL change no state.
REQ-027 A tag retired in cycle N SHALL NOT be grantable before cycle N+1.
REQ-028 Simultaneous grant and retire SHALL leave outstanding_o unchanged; grant alone SHALL add 1; retire alone SHALL subtract 1.
REQ-029 full_o SHALL be 1 when outstanding_o equals 2**EXT_TID_WIDTH; empty_o SHALL be 1 when it equals 0.
REQ-030 flush_i SHALL clear all valid bits and outstanding_o at the next edge, overriding retire; stored payload SHALL be retained.

Reset
REQ-031 Reset SHALL clear all valid bits, all payload and outstanding_o to 0.
REQ-032 After reset: empty_o=1, full_o=0, alloc_tid_o=0, and alloc_gnt_o follows alloc_req_i.
REQ-033 Reset mid-operation SHALL discard all outstanding tags without generating any response indication.

Structure
REQ-034 The descriptor struct type and the OPC_BUF_WIDTH/OPC_BUF_DEPTH constants SHALL reside in the shared mchan package.
REQ-035 The free-tag lowest-index priority encoder SHALL be a sub-module, tid_prio_enc.

Verification
REQ-036 Reset, then 16 consecutive alloc_req_i -> tags 0..15 granted in order; full_o=1 after the 16th; a 17th request gets alloc_gnt_o=0.
REQ-037 Allocate tag 3 with opc=0x001, len=0x40, then respond with tid=3 -> tcdm_opc_o=0x000 with SWAP_OPC=1, and 0x001 with SWAP_OPC=0.
REQ-038 Full buffer: retire tag 5 with last while requesting -> no grant that cycle; tag 5 granted the next cycle; outstanding_o stays at 16.
REQ-039 Response to unallocated tag 7 -> rsp_err_o=1 and outstanding_o unchanged.
REQ-040 Hold 4 tags live, pulse flush_i together with alloc_req_i -> no grant, then outstanding_o=0, empty_o=1, and the next grant returns tag 0.
REQ-041 Assert rst_ni low with 10 tags live -> outputs immediately at reset values; after release, the first grant returns tag 0.
